plc_data_mem: RTL and testbench

Data-side responder for the PLC word CPU. It serves the CPU's word-memory port (DW_*) and bit-memory port (DB_*) with an OE/WE/RDY handshake and configurable wait states. A 16-bit input image and a 16-bit output image are mapped into the low bit-address space, so PLC programs reach field I/O through ordinary bit loads and stores. It sits between the CPU and the physical I/O, as the other end of the CPU's data interface.

---
 rtl/plc_data_mem_if.sv | 36 +++
 rtl/plc_data_mem.sv | 181 ++++++++++++++++++
 tb/tb_plc_data_mem.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/plc_data_mem_if.sv
// CPU data-side bus: word port (DW_*) and bit port (DB_*) with OE/WE/RDY handshakes.
interface plc_data_mem_if #(
    parameter int unsigned DA_W = 16,
    parameter int unsigned DW_W = 32,
    parameter int unsigned BA_W = 12
) ();

    logic [DA_W-1:0] DW_A;
    logic [DW_W-1:0] DW_O;
    logic [DW_W-1:0] DW_I;
    logic            DW_OE;
    logic            DW_WE;
    logic            DW_RDY;

    logic [BA_W-1:0] DB_A;
    logic            DB_O;
    logic            DB_I;
    logic            DB_OE;
    logic            DB_WE;
    logic            DB_RDY;

    modport master (
        output DW_A, DW_O, DW_OE, DW_WE,
        output DB_A, DB_O, DB_OE, DB_WE,
        input  DW_I, DW_RDY,
        input  DB_I, DB_RDY
    );

    modport slave (
        input  DW_A, DW_O, DW_OE, DW_WE,
        input  DB_A, DB_O, DB_OE, DB_WE,
        output DW_I, DW_RDY,
        output DB_I, DB_RDY
    );

endinterface

// File: rtl/plc_data_mem.sv
// Data-side responder for the PLC word CPU: word RAM, bit RAM and a 16+16 bit field I/O image
// behind two independent OE/WE/RDY handshake ports with configurable wait states.

// Per-port handshake FSM; fire marks the edge that enters ACK (capture / commit edge).
module plc_data_mem_hs #(
    parameter int unsigned N_WAIT = 0
) (
    input  logic CLK,
    input  logic CLR,
    input  logic req,
    output logic rdy,
    output logic fire
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] WAIT_LD = CW'(N_WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (req) begin
                    cnt_nxt   = WAIT_LD;
                    state_nxt = (WAIT_LD != '0) ? S_WAIT : S_ACK;
                end
            end
            S_WAIT: begin
                // Dropping the request while stalled abandons the access.
                if (!req) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state_nxt = S_ACK;
                    end
                end
            end
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rdy  = 1'b0;
        fire = 1'b0;
        if (!CLR) begin
            case (state)
                S_IDLE: begin
                    rdy  = !req;
                    fire = req && (WAIT_LD == '0);
                end
                S_WAIT:  fire = req && (cnt == CW'(1));
                S_ACK:   rdy  = 1'b1;
                default: begin
                    rdy  = 1'b0;
                    fire = 1'b0;
                end
            endcase
        end
    end

endmodule

module plc_data_mem #(
    parameter int unsigned DA_W     = 16,
    parameter int unsigned DW_W     = 32,
    parameter int unsigned BA_W     = 12,
    parameter int unsigned DW_DEPTH = 1024,
    parameter int unsigned DW_WAIT  = 1,
    parameter int unsigned DB_WAIT  = 0
) (
    input  logic               CLK,
    input  logic               CLR,
    plc_data_mem_if.slave      bus,
    input  logic [15:0]        IN_BITS,
    output logic [15:0]        OUT_BITS
);

    localparam int unsigned DW_AW = (DW_DEPTH > 1) ? $clog2(DW_DEPTH) : 1;
    localparam int unsigned BIT_N = 2 ** BA_W;
    localparam int unsigned PG_W  = BA_W - 4;

    logic [DW_W-1:0] word_mem [DW_DEPTH];
    logic            bit_ram  [BIT_N];

    logic             dw_req;
    logic             db_req;
    logic             dw_fire;
    logic             db_fire;
    logic             dw_hit;
    logic [DW_AW-1:0] dw_idx;
    logic [PG_W-1:0]  db_page;
    logic [3:0]       db_sel;
    logic             db_in;
    logic             db_out;

    assign dw_req  = bus.DW_OE | bus.DW_WE;
    assign db_req  = bus.DB_OE | bus.DB_WE;
    assign dw_hit  = 32'(bus.DW_A) < DW_DEPTH;
    assign dw_idx  = DW_AW'(bus.DW_A);
    assign db_page = bus.DB_A[BA_W-1:4];
    assign db_sel  = bus.DB_A[3:0];
    assign db_in   = (db_page == PG_W'(0));
    assign db_out  = (db_page == PG_W'(1));

    plc_data_mem_hs #(.N_WAIT(DW_WAIT)) u_dw_hs (
        .CLK  (CLK),
        .CLR  (CLR),
        .req  (dw_req),
        .rdy  (bus.DW_RDY),
        .fire (dw_fire)
    );

    plc_data_mem_hs #(.N_WAIT(DB_WAIT)) u_db_hs (
        .CLK  (CLK),
        .CLR  (CLR),
        .req  (db_req),
        .rdy  (bus.DB_RDY),
        .fire (db_fire)
    );

    // Arrays survive CLR; fire is already suppressed during CLR.
    always_ff @(posedge CLK) begin
        if (dw_fire && bus.DW_WE && dw_hit) begin
            word_mem[dw_idx] <= bus.DW_O;
        end
        if (db_fire && bus.DB_WE && !db_in && !db_out) begin
            bit_ram[bus.DB_A] <= bus.DB_O;
        end
    end

    // Read capture and output image; WE wins over OE, so a write leaves read data alone.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            bus.DW_I <= '0;
            bus.DB_I <= 1'b0;
            OUT_BITS <= '0;
        end else begin
            if (dw_fire && !bus.DW_WE) begin
                bus.DW_I <= dw_hit ? word_mem[dw_idx] : '0;
            end
            if (db_fire) begin
                if (bus.DB_WE) begin
                    if (db_out) begin
                        OUT_BITS[db_sel] <= bus.DB_O;
                    end
                end else if (db_in) begin
                    bus.DB_I <= IN_BITS[db_sel];
                end else if (db_out) begin
                    bus.DB_I <= OUT_BITS[db_sel];
                end else begin
                    bus.DB_I <= bit_ram[bus.DB_A];
                end
            end
        end
    end

endmodule

// File: tb/tb_plc_data_mem.sv
// Directed bench for plc_data_mem: two instances (word wait 1 / bit wait 0, and word wait 3 / bit wait 2).
module tb_plc_data_mem;

    logic        CLK;
    logic        CLR;
    logic [15:0] in_bits;
    logic [15:0] out_a;
    logic [15:0] out_b;
    int          checks;
    int          errors;
    int          lat;

    plc_data_mem_if #(.DA_W(16), .DW_W(32), .BA_W(12)) bus_a ();
    plc_data_mem_if #(.DA_W(16), .DW_W(32), .BA_W(12)) bus_b ();

    plc_data_mem #(
        .DA_W(16), .DW_W(32), .BA_W(12), .DW_DEPTH(1024), .DW_WAIT(1), .DB_WAIT(0)
    ) dut (
        .CLK      (CLK),
        .CLR      (CLR),
        .bus      (bus_a.slave),
        .IN_BITS  (in_bits),
        .OUT_BITS (out_a)
    );

    plc_data_mem #(
        .DA_W(16), .DW_W(32), .BA_W(12), .DW_DEPTH(1024), .DW_WAIT(3), .DB_WAIT(2)
    ) dut3 (
        .CLK      (CLK),
        .CLR      (CLR),
        .bus      (bus_b.slave),
        .IN_BITS  (in_bits),
        .OUT_BITS (out_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Full word access: hold request until RDY, return cycles to RDY, end in IDLE.
    task automatic w_acc(input bit sel, input logic oe, input logic we,
                         input logic [15:0] a, input logic [31:0] d, output int n);
        logic rdy;
        if (sel) begin
            bus_b.DW_OE = oe; bus_b.DW_WE = we; bus_b.DW_A = a; bus_b.DW_O = d;
        end else begin
            bus_a.DW_OE = oe; bus_a.DW_WE = we; bus_a.DW_A = a; bus_a.DW_O = d;
        end
        n   = 0;
        rdy = 1'b0;
        while (!rdy && n < 32) begin
            cyc();
            n++;
            rdy = sel ? bus_b.DW_RDY : bus_a.DW_RDY;
        end
        chk("w_rdy_timeout", 32'(rdy), 32'd1);
        if (sel) begin
            bus_b.DW_OE = 1'b0; bus_b.DW_WE = 1'b0;
        end else begin
            bus_a.DW_OE = 1'b0; bus_a.DW_WE = 1'b0;
        end
        cyc();
    endtask

    task automatic b_acc(input bit sel, input logic oe, input logic we,
                         input logic [11:0] a, input logic d, output int n);
        logic rdy;
        if (sel) begin
            bus_b.DB_OE = oe; bus_b.DB_WE = we; bus_b.DB_A = a; bus_b.DB_O = d;
        end else begin
            bus_a.DB_OE = oe; bus_a.DB_WE = we; bus_a.DB_A = a; bus_a.DB_O = d;
        end
        n   = 0;
        rdy = 1'b0;
        while (!rdy && n < 32) begin
            cyc();
            n++;
            rdy = sel ? bus_b.DB_RDY : bus_a.DB_RDY;
        end
        chk("b_rdy_timeout", 32'(rdy), 32'd1);
        if (sel) begin
            bus_b.DB_OE = 1'b0; bus_b.DB_WE = 1'b0;
        end else begin
            bus_a.DB_OE = 1'b0; bus_a.DB_WE = 1'b0;
        end
        cyc();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        CLR = 1'b1;
        in_bits = 16'h0000;
        bus_a.DW_A = '0; bus_a.DW_O = '0; bus_a.DW_OE = 1'b0; bus_a.DW_WE = 1'b0;
        bus_a.DB_A = '0; bus_a.DB_O = 1'b0; bus_a.DB_OE = 1'b0; bus_a.DB_WE = 1'b0;
        bus_b.DW_A = '0; bus_b.DW_O = '0; bus_b.DW_OE = 1'b0; bus_b.DW_WE = 1'b0;
        bus_b.DB_A = '0; bus_b.DB_O = 1'b0; bus_b.DB_OE = 1'b0; bus_b.DB_WE = 1'b0;

        // Reset: RDY low during CLR, registers cleared after
        cyc();
        chk("clr_dw_rdy", 32'(bus_a.DW_RDY), 32'd0);
        chk("clr_db_rdy", 32'(bus_a.DB_RDY), 32'd0);
        cyc();
        CLR = 1'b0;
        #1;
        chk("rst_dw_i", bus_a.DW_I, 32'h0);
        chk("rst_db_i", 32'(bus_a.DB_I), 32'd0);
        chk("rst_out", 32'(out_a), 32'h0);
        chk("idle_dw_rdy", 32'(bus_a.DW_RDY), 32'd1);
        chk("idle_db_rdy", 32'(bus_a.DB_RDY), 32'd1);

        // Word read with one wait state, cycle by cycle
        w_acc(1'b0, 1'b0, 1'b1, 16'd5, 32'hDEADBEEF, lat);
        chk("wr5_lat", 32'(lat), 32'd2);
        bus_a.DW_OE = 1'b1; bus_a.DW_A = 16'd5;
        #1;
        chk("rd5_c0_rdy", 32'(bus_a.DW_RDY), 32'd0);
        cyc();
        chk("rd5_c1_rdy", 32'(bus_a.DW_RDY), 32'd0);
        cyc();
        chk("rd5_c2_rdy", 32'(bus_a.DW_RDY), 32'd1);
        chk("rd5_c2_data", bus_a.DW_I, 32'hDEADBEEF);
        bus_a.DW_OE = 1'b0;
        cyc();
        chk("rd5_c3_idle", 32'(bus_a.DW_RDY), 32'd1);

        // Write then read, and out-of-range address
        w_acc(1'b0, 1'b0, 1'b1, 16'd7, 32'h12345678, lat);
        w_acc(1'b0, 1'b1, 1'b0, 16'd7, 32'h0, lat);
        chk("rd7_data", bus_a.DW_I, 32'h12345678);
        chk("rd7_lat", 32'(lat), 32'd2);
        w_acc(1'b0, 1'b0, 1'b1, 16'd2000, 32'hFFFFFFFF, lat);
        chk("wr2000_keeps_dw_i", bus_a.DW_I, 32'h12345678);
        w_acc(1'b0, 1'b1, 1'b0, 16'd2000, 32'h0, lat);
        chk("rd2000_zero", bus_a.DW_I, 32'h0);

        // Bit map: input image, output image, bit RAM
        in_bits = 16'h0004;
        b_acc(1'b0, 1'b1, 1'b0, 12'h002, 1'b0, lat);
        chk("rdb2_data", 32'(bus_a.DB_I), 32'd1);
        chk("rdb2_lat", 32'(lat), 32'd1);
        b_acc(1'b0, 1'b0, 1'b1, 12'h013, 1'b1, lat);
        chk("wrb13_out", 32'(out_a), 32'h0008);
        b_acc(1'b0, 1'b0, 1'b1, 12'h002, 1'b0, lat);
        b_acc(1'b0, 1'b1, 1'b0, 12'h002, 1'b0, lat);
        chk("rdb2_after_wr", 32'(bus_a.DB_I), 32'd1);
        chk("out_after_in_wr", 32'(out_a), 32'h0008);
        in_bits = 16'h0000;
        b_acc(1'b0, 1'b1, 1'b0, 12'h002, 1'b0, lat);
        chk("rdb2_live_in", 32'(bus_a.DB_I), 32'd0);
        b_acc(1'b0, 1'b1, 1'b0, 12'h013, 1'b0, lat);
        chk("rdb13_out", 32'(bus_a.DB_I), 32'd1);
        b_acc(1'b0, 1'b0, 1'b1, 12'h123, 1'b1, lat);
        b_acc(1'b0, 1'b1, 1'b0, 12'h123, 1'b0, lat);
        chk("rdb123_one", 32'(bus_a.DB_I), 32'd1);
        b_acc(1'b0, 1'b0, 1'b1, 12'h123, 1'b0, lat);
        b_acc(1'b0, 1'b1, 1'b0, 12'h123, 1'b0, lat);
        chk("rdb123_zero", 32'(bus_a.DB_I), 32'd0);

        // Aborts on the wait-3 instance
        w_acc(1'b1, 1'b0, 1'b1, 16'd10, 32'h11111111, lat);
        chk("b_wr10_lat", 32'(lat), 32'd4);
        w_acc(1'b1, 1'b0, 1'b1, 16'd9, 32'hA5A5A5A5, lat);
        w_acc(1'b1, 1'b1, 1'b0, 16'd9, 32'h0, lat);
        chk("b_rd9_data", bus_b.DW_I, 32'hA5A5A5A5);
        bus_b.DW_OE = 1'b1; bus_b.DW_A = 16'd10;
        cyc();
        cyc();
        bus_b.DW_OE = 1'b0;
        #1;
        chk("abort_rd_c2_rdy", 32'(bus_b.DW_RDY), 32'd0);
        cyc();
        chk("abort_rd_c3_rdy", 32'(bus_b.DW_RDY), 32'd1);
        chk("abort_rd_dw_i", bus_b.DW_I, 32'hA5A5A5A5);
        bus_b.DW_WE = 1'b1; bus_b.DW_A = 16'd10; bus_b.DW_O = 32'h22222222;
        cyc();
        cyc();
        bus_b.DW_WE = 1'b0;
        cyc();
        chk("abort_wr_c3_rdy", 32'(bus_b.DW_RDY), 32'd1);
        w_acc(1'b1, 1'b1, 1'b0, 16'd10, 32'h0, lat);
        chk("abort_wr_mem", bus_b.DW_I, 32'h11111111);
        b_acc(1'b1, 1'b1, 1'b0, 12'h013, 1'b0, lat);
        chk("b_db_lat", 32'(lat), 32'd3);

        // CLR during the wait cycle of a word write
        bus_a.DW_WE = 1'b1; bus_a.DW_A = 16'd7; bus_a.DW_O = 32'hCAFEF00D;
        cyc();
        CLR = 1'b1;
        #1;
        chk("clrw_dw_rdy", 32'(bus_a.DW_RDY), 32'd0);
        chk("clrw_db_rdy", 32'(bus_a.DB_RDY), 32'd0);
        cyc();
        CLR = 1'b0;
        bus_a.DW_WE = 1'b0;
        #1;
        chk("clrw_idle_rdy", 32'(bus_a.DW_RDY), 32'd1);
        chk("clrw_out", 32'(out_a), 32'h0);
        chk("clrw_dw_i", bus_a.DW_I, 32'h0);
        w_acc(1'b0, 1'b1, 1'b0, 16'd7, 32'h0, lat);
        chk("clrw_mem_kept", bus_a.DW_I, 32'h12345678);

        // Parallel word read and bit write
        bus_a.DW_OE = 1'b1; bus_a.DW_A = 16'd7;
        bus_a.DB_WE = 1'b1; bus_a.DB_A = 12'h015; bus_a.DB_O = 1'b1;
        #1;
        chk("par_c0_dw_rdy", 32'(bus_a.DW_RDY), 32'd0);
        chk("par_c0_db_rdy", 32'(bus_a.DB_RDY), 32'd0);
        cyc();
        chk("par_c1_db_rdy", 32'(bus_a.DB_RDY), 32'd1);
        chk("par_c1_dw_rdy", 32'(bus_a.DW_RDY), 32'd0);
        chk("par_c1_out", 32'(out_a), 32'h0020);
        bus_a.DB_WE = 1'b0;
        cyc();
        chk("par_c2_dw_rdy", 32'(bus_a.DW_RDY), 32'd1);
        chk("par_c2_dw_i", bus_a.DW_I, 32'h12345678);
        bus_a.DW_OE = 1'b0;
        cyc();

        // OE and WE together: write wins, read data untouched
        w_acc(1'b0, 1'b1, 1'b1, 16'd7, 32'h0BADCAFE, lat);
        chk("coll_lat", 32'(lat), 32'd2);
        chk("coll_dw_i", bus_a.DW_I, 32'h12345678);
        w_acc(1'b0, 1'b1, 1'b0, 16'd7, 32'h0, lat);
        chk("coll_mem", bus_a.DW_I, 32'h0BADCAFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
